// File: rtl/axis_vid_frame_sync.sv
// AXI4-Stream video frame synchroniser: hunts for SOF, checks line/frame geometry
// on every accepted beat and forwards well-formed beats through a 2-entry skid buffer.
module axis_vid_frame_sync #(
  parameter int DATA_WIDTH = 32,
  parameter int H_ACTIVE   = 1920,
  parameter int V_ACTIVE   = 1080
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                    s_axis_tlast,
  input  logic                    s_axis_tuser,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tuser,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  input  logic                    resync,
  output logic                    locked,
  output logic                    frame_err,
  output logic [15:0]             frame_cnt,
  output logic [7:0]              err_cnt
);

  localparam int KW = DATA_WIDTH / 8;
  localparam int PW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int LW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int BW = DATA_WIDTH + KW + 2;
  localparam logic [PW-1:0] PIX_LAST  = PW'(H_ACTIVE - 1);
  localparam logic [LW-1:0] LINE_LAST = LW'(V_ACTIVE - 1);

  typedef enum logic {HUNT = 1'b0, PASS = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] pix_q, pix_d, pix_e;
  logic [LW-1:0] line_q, line_d, line_e;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic [7:0]    err_cnt_q, err_cnt_d;
  logic          frame_err_q, frame_err_d;
  logic          locked_q, locked_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [BW-1:0] head_q, head_d, skid_q, skid_d, in_beat;
  logic          m_tvalid_q, m_tvalid_d, s_tready_q, s_tready_d;
  logic          acc, pop, fwd, hunting, sof_err, pos_ok, zero_err, eol_err;

  // Classify the accepted beat: an SOF beat always re-anchors the position at (0,0)
  always_comb begin
    acc         = s_axis_tvalid && s_tready_q;
    hunting     = (state_q == HUNT) || resync;
    state_d     = state_q;
    pix_d       = pix_q;
    line_d      = line_q;
    frame_cnt_d = frame_cnt_q;
    fwd         = 1'b0;
    frame_err_d = 1'b0;
    if (s_axis_tuser) begin
      pix_e   = '0;
      line_e  = '0;
      sof_err = !hunting && ((pix_q != '0) || (line_q != '0));
      pos_ok  = acc;
    end else begin
      pix_e   = pix_q;
      line_e  = line_q;
      sof_err = 1'b0;
      pos_ok  = acc && !hunting;
    end
    zero_err = !s_axis_tuser && (pix_q == '0) && (line_q == '0);
    eol_err  = s_axis_tlast != (pix_e == PIX_LAST);
    if (!pos_ok) begin
      if (resync) begin
        state_d = HUNT;
        pix_d   = '0;
        line_d  = '0;
      end else begin
        state_d = state_q;
      end
    end else if (zero_err || eol_err) begin
      frame_err_d = 1'b1;
      state_d     = HUNT;
      pix_d       = '0;
      line_d      = '0;
    end else begin
      fwd         = 1'b1;
      frame_err_d = sof_err;
      state_d     = PASS;
      if (pix_e == PIX_LAST) begin
        pix_d = '0;
        if (line_e == LINE_LAST) begin
          line_d      = '0;
          frame_cnt_d = frame_cnt_q + 16'd1;
        end else begin
          line_d = line_e + LW'(1'b1);
        end
      end else begin
        pix_d  = pix_e + PW'(1'b1);
        line_d = line_e;
      end
    end
    if (frame_err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
    locked_d = (state_d == PASS);
  end

  // Skid buffer: head_q is the output register, skid_q catches a beat during a stall
  always_comb begin
    pop     = m_tvalid_q && m_axis_tready;
    in_beat = {s_axis_tuser, s_axis_tlast, s_axis_tkeep, s_axis_tdata};
    head_d  = head_q;
    skid_d  = skid_q;
    case (cnt_q)
      2'd0: begin
        if (fwd) head_d = in_beat;
        else     head_d = head_q;
      end
      2'd1: begin
        if (pop) begin
          if (fwd) head_d = in_beat;
          else     head_d = head_q;
        end else begin
          if (fwd) skid_d = in_beat;
          else     skid_d = skid_q;
        end
      end
      2'd2: begin
        if (pop) head_d = skid_q;
        else     head_d = head_q;
      end
      default: begin
        head_d = head_q;
        skid_d = skid_q;
      end
    endcase
    cnt_d      = cnt_q + {1'b0, fwd} - {1'b0, pop};
    m_tvalid_d = (cnt_d != 2'd0);
    s_tready_d = (cnt_d <= 2'd1);
  end

  // State, counters and buffer registers with synchronous active-low reset
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= HUNT;
      pix_q       <= '0;
      line_q      <= '0;
      frame_cnt_q <= 16'd0;
      err_cnt_q   <= 8'd0;
      frame_err_q <= 1'b0;
      locked_q    <= 1'b0;
      cnt_q       <= 2'd0;
      head_q      <= '0;
      skid_q      <= '0;
      m_tvalid_q  <= 1'b0;
      s_tready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_q       <= pix_d;
      line_q      <= line_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
      frame_err_q <= frame_err_d;
      locked_q    <= locked_d;
      cnt_q       <= cnt_d;
      head_q      <= head_d;
      skid_q      <= skid_d;
      m_tvalid_q  <= m_tvalid_d;
      s_tready_q  <= s_tready_d;
    end
  end

  assign s_axis_tready = s_tready_q;
  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tdata  = head_q[DATA_WIDTH-1:0];
  assign m_axis_tkeep  = head_q[DATA_WIDTH+KW-1:DATA_WIDTH];
  assign m_axis_tlast  = head_q[BW-2];
  assign m_axis_tuser  = head_q[BW-1];
  assign locked        = locked_q;
  assign frame_err     = frame_err_q;
  assign frame_cnt     = frame_cnt_q;
  assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_axis_vid_frame_sync.sv
// Randomised bench for axis_vid_frame_sync (4x2 frames) against a position-index
// reference model that predicts the output beat queue, flags and counters each cycle.
module tb_axis_vid_frame_sync;
  localparam int DW = 32;
  localparam int KW = 4;
  localparam int H  = 4;
  localparam int V  = 2;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic [KW-1:0] s_axis_tkeep = '0;
  logic          s_axis_tlast = 1'b0, s_axis_tuser = 1'b0, s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tlast, m_axis_tuser, m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic          resync = 1'b0;
  logic          locked, frame_err;
  logic [15:0]   frame_cnt;
  logic [7:0]    err_cnt;

  axis_vid_frame_sync #(.DATA_WIDTH(DW), .H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
    .s_axis_tuser(s_axis_tuser), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .resync(resync), .locked(locked), .frame_err(frame_err),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic          u;
    logic          l;
    logic [KW-1:0] k;
    logic [DW-1:0] d;
  } beat_t;

  beat_t src[$];
  beat_t exp_q[$];
  int    checks = 0, errors = 0;
  bit    m_locked = 1'b0, m_ferr = 1'b0, rst_last = 1'b1;
  int    pos = 0, m_fcnt = 0, m_ecnt = 0;
  int    out_cnt = 0, out_sof = 0, out_eol = 0, ferr_seen = 0;
  int    rdy_mode = 0;
  bit    gap_en = 1'b0, rand_rs = 1'b0, resync_req = 1'b0, rst_on = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: compare outputs, drive the next inputs, advance the model past the coming edge
  task automatic cycle();
    beat_t cur;
    bit    acc, pop, fwd, bad, sof_err;
    int    p;
    @(negedge aclk);
    chk("s_tready", 64'(s_axis_tready), 64'(!rst_last && exp_q.size() <= 1));
    chk("m_tvalid", 64'(m_axis_tvalid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0)
      chk("m_beat", 64'({m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata}), 64'(exp_q[0]));
    chk("locked", 64'(locked), 64'(m_locked));
    chk("frame_err", 64'(frame_err), 64'(m_ferr));
    chk("frame_cnt", 64'(frame_cnt), 64'(m_fcnt));
    chk("err_cnt", 64'(err_cnt), 64'(m_ecnt));
    if (frame_err === 1'b1) ferr_seen++;

    aresetn = !rst_on;
    if (src.size() != 0 && (s_axis_tvalid || !gap_en || $urandom_range(3) != 0)) begin
      cur = src[0];
      s_axis_tvalid = 1'b1;
    end else begin
      cur.u = 1'($urandom); cur.l = 1'($urandom); cur.k = KW'($urandom); cur.d = $urandom;
      s_axis_tvalid = 1'b0;
    end
    {s_axis_tuser, s_axis_tlast, s_axis_tkeep, s_axis_tdata} = cur;
    case (rdy_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = ~m_axis_tready;
      2:       m_axis_tready = 1'($urandom_range(1));
      default: m_axis_tready = 1'b0;
    endcase
    resync = resync_req || (rand_rs && $urandom_range(31) == 0);
    resync_req = 1'b0;

    if (!aresetn) begin
      exp_q.delete();
      m_locked = 1'b0; pos = 0; m_fcnt = 0; m_ecnt = 0; m_ferr = 1'b0; rst_last = 1'b1;
    end else begin
      acc = s_axis_tvalid && !rst_last && exp_q.size() <= 1;
      pop = exp_q.size() != 0 && m_axis_tready;
      fwd = 1'b0; bad = 1'b0; sof_err = 1'b0; p = -1;
      if (resync) begin m_locked = 1'b0; pos = 0; end
      if (acc) begin
        void'(src.pop_front());
        if (cur.u) begin
          p = 0;
          sof_err = m_locked && pos != 0;
        end else if (m_locked) begin
          p = pos;
          bad = (pos == 0);
        end
        if (p >= 0) begin
          if (cur.l != ((p % H) == H - 1)) bad = 1'b1;
          if (bad) begin
            m_locked = 1'b0; pos = 0;
          end else begin
            fwd = 1'b1; m_locked = 1'b1; pos = (p + 1) % (H * V);
            if (p == H * V - 1) m_fcnt = (m_fcnt + 1) % 65536;
          end
        end
      end
      m_ferr = bad || (fwd && sof_err);
      if (m_ferr && m_ecnt < 255) m_ecnt++;
      if (pop) begin
        out_cnt++;
        out_sof += int'(exp_q[0].u);
        out_eol += int'(exp_q[0].l);
        void'(exp_q.pop_front());
      end
      if (fwd) exp_q.push_back(cur);
      rst_last = 1'b0;
    end
  endtask

  task automatic add_beat(input bit u, input bit l);
    beat_t b;
    b.u = u; b.l = l; b.k = KW'($urandom); b.d = $urandom;
    src.push_back(b);
  endtask

  task automatic add_frame();
    for (int i = 0; i < H * V; i++) add_beat(i == 0, (i % H) == H - 1);
  endtask

  task automatic drain();
    int n = 0;
    while ((src.size() != 0 || exp_q.size() != 0) && n < 5000) begin
      cycle();
      n++;
    end
    chk("drain_bound", 64'(n < 5000), 64'd1);
    repeat (3) cycle();
  endtask

  task automatic do_reset();
    src.delete();
    rst_on = 1'b1;
    cycle();
    rst_on = 1'b0;
    cycle();
    chk("rst_tready", 64'(s_axis_tready), 64'd0);
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_locked", 64'(locked), 64'd0);
    chk("rst_ferr", 64'(frame_err), 64'd0);
    chk("rst_fcnt", 64'(frame_cnt), 64'd0);
    chk("rst_ecnt", 64'(err_cnt), 64'd0);
    cycle();
    chk("tready_rise", 64'(s_axis_tready), 64'd1);
    out_cnt = 0; out_sof = 0; out_eol = 0; ferr_seen = 0;
  endtask

  initial begin
    repeat (2) @(posedge aclk);

    // Junk before SOF, then one clean frame
    do_reset(); rdy_mode = 0;
    repeat (3) add_beat(1'b0, 1'b0);
    add_frame();
    drain();
    chk("f1_out", 64'(out_cnt), 64'd8);
    chk("f1_sof", 64'(out_sof), 64'd1);
    chk("f1_eol", 64'(out_eol), 64'd2);
    chk("f1_fcnt", 64'(frame_cnt), 64'd1);
    chk("f1_locked", 64'(locked), 64'd1);

    // Two frames against a toggling downstream ready
    do_reset(); rdy_mode = 1;
    add_frame(); add_frame();
    drain();
    chk("f2_out", 64'(out_cnt), 64'd16);
    chk("f2_fcnt", 64'(frame_cnt), 64'd2);

    // Early tlast on line 0, then a clean frame
    do_reset(); rdy_mode = 0;
    add_beat(1'b1, 1'b0); add_beat(1'b0, 1'b0); add_beat(1'b0, 1'b1);
    add_frame();
    drain();
    chk("eol_pulses", 64'(ferr_seen), 64'd1);
    chk("eol_ecnt", 64'(err_cnt), 64'd1);
    chk("eol_fcnt", 64'(frame_cnt), 64'd1);
    chk("eol_out", 64'(out_cnt), 64'd10);

    // Misplaced SOF at line 1 pixel 2 restarts the frame
    do_reset(); rdy_mode = 0;
    for (int i = 0; i < 6; i++) add_beat(i == 0, (i % H) == H - 1);
    add_beat(1'b1, 1'b0);
    for (int i = 1; i < H * V; i++) add_beat(1'b0, (i % H) == H - 1);
    drain();
    chk("sof_out", 64'(out_cnt), 64'd14);
    chk("sof_fcnt", 64'(frame_cnt), 64'd1);
    chk("sof_ecnt", 64'(err_cnt), 64'd1);

    // Resync with two beats buffered
    do_reset(); rdy_mode = 3;
    add_frame();
    repeat (4) cycle();
    resync_req = 1'b1;
    cycle();
    cycle();
    chk("rs_locked", 64'(locked), 64'd0);
    chk("rs_tvalid", 64'(m_axis_tvalid), 64'd1);
    rdy_mode = 0;
    drain();
    add_frame();
    drain();
    chk("rs_out", 64'(out_cnt), 64'd10);
    chk("rs_fcnt", 64'(frame_cnt), 64'd1);

    // Randomised frames with corrupted markers, gaps, stalls and resyncs
    do_reset(); rdy_mode = 2; gap_en = 1'b1; rand_rs = 1'b1;
    for (int f = 0; f < 25; f++) begin
      for (int i = 0; i < H * V; i++) begin
        add_beat((i == 0) ^ ($urandom_range(15) == 0), ((i % H) == H - 1) ^ ($urandom_range(15) == 0));
      end
    end
    drain();
    gap_en = 1'b0; rand_rs = 1'b0;

    // Error counter saturation, then reset in the middle of a frame
    do_reset(); rdy_mode = 0;
    for (int i = 0; i < 300; i++) begin
      add_beat(1'b1, 1'b0);
      add_beat(1'b0, 1'b1);
    end
    drain();
    chk("sat_ecnt", 64'(err_cnt), 64'hFF);
    chk("sat_out", 64'(out_cnt), 64'd300);
    add_frame();
    rdy_mode = 3;
    repeat (4) cycle();
    chk("mid_tvalid", 64'(m_axis_tvalid), 64'd1);
    rdy_mode = 0;
    do_reset();
    add_frame();
    drain();
    chk("post_fcnt", 64'(frame_cnt), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
